hilo_muldiv_unit: RTL

Parametrised, multi-cycle multiply/divide unit owning the HI/LO architectural registers for the MIPS pipeline. It replaces the single-cycle HI/LO arithmetic in the EX-stage ALU with an iterative shift-add multiplier and restoring divider behind a start/busy/done handshake. It sits beside the ALU in EX; the hazard unit stalls MFHI/MFLO and new mult/div ops on `Busy_OUT`.

---
 rtl/hilo_muldiv_pkg.sv | 32 +++
 rtl/hilo_muldiv_if.sv | 31 +++
 rtl/muldiv_step.sv | 48 ++++
 rtl/hilo_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_pkg
// Brief    : Shared types and cycle-count helper for the HI/LO mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Iteration count: divide retires one quotient bit per cycle, multiply MUL_STEP bits.
  function automatic int muldiv_cycles(input int data_width, input int mul_step, input logic is_div);
    return is_div ? data_width : data_width / mul_step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_if
// Brief    : Request/response bundle between the EX stage and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start_IN;
  logic [2:0]            Op_IN;
  logic [DATA_WIDTH-1:0] OperandA_IN;
  logic [DATA_WIDTH-1:0] OperandB_IN;
  logic                  Flush_IN;
  logic                  Busy_OUT;
  logic                  Done_OUT;
  logic                  DivZero_OUT;
  logic [DATA_WIDTH-1:0] HI_OUT;
  logic [DATA_WIDTH-1:0] LO_OUT;

  modport master (
    output Start_IN, Op_IN, OperandA_IN, OperandB_IN, Flush_IN,
    input  Busy_OUT, Done_OUT, DivZero_OUT, HI_OUT, LO_OUT
  );

  modport slave (
    input  Start_IN, Op_IN, OperandA_IN, OperandB_IN, Flush_IN,
    output Busy_OUT, Done_OUT, DivZero_OUT, HI_OUT, LO_OUT
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One combinational iteration: MUL_STEP-bit shift-add multiply or
//            one restoring divide step on a shared {upper,lower} accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STEP   = 1
) (
  input  logic                    mode_div,
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0]   operand,
  output logic [2*DATA_WIDTH-1:0] acc_out
);
  localparam int W = DATA_WIDTH;

  logic [W+MUL_STEP-1:0] operand_ext;
  logic [W+MUL_STEP-1:0] addend;
  logic [W+MUL_STEP-1:0] mul_sum;
  logic [W:0]            rem_shift;
  logic [W:0]            rem_diff;

  always_comb begin
    operand_ext = {{MUL_STEP{1'b0}}, operand};
    addend      = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (acc_in[j]) begin
        addend = addend + (operand_ext << j);
      end
    end
    mul_sum   = {{MUL_STEP{1'b0}}, acc_in[2*W-1:W]} + addend;
    // Lower half holds the not-yet-consumed multiplier / dividend bits.
    rem_shift = {acc_in[2*W-1:W], acc_in[W-1]};
    rem_diff  = rem_shift - {1'b0, operand};

    acc_out = {mul_sum, acc_in[W-1:MUL_STEP]};
    if (mode_div) begin
      if (rem_diff[W]) begin
        acc_out = {rem_shift[W-1:0], acc_in[W-2:0], 1'b0};
      end else begin
        acc_out = {rem_diff[W-1:0], acc_in[W-2:0], 1'b1};
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Brief    : Iterative multiply/divide unit owning architectural HI/LO.
//            Define HILO_MULDIV_ACCUM_EN to implement MADD/MSUB.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STEP   = 1
) (
  input  logic         CLOCK,
  input  logic         RESET,
  hilo_muldiv_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int C_MUL_N = muldiv_cycles(DATA_WIDTH, MUL_STEP, 1'b0);
  localparam int C_DIV_N = muldiv_cycles(DATA_WIDTH, MUL_STEP, 1'b1);
  localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(C_MUL_N - 1);
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(C_DIV_N - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d, step_acc;
  logic [W-1:0]     opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             in_signed, in_is_div, a_neg, b_neg, run_div;
  logic [W-1:0]     a_mag, b_mag, quot, rem;
  logic [2*W-1:0]   prod;

  always_comb begin
    op_in     = op_e'(bus.Op_IN);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV) ||
                (op_in == OP_MADD) || (op_in == OP_MSUB);
    in_is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
    a_neg     = in_signed & bus.OperandA_IN[W-1];
    b_neg     = in_signed & bus.OperandB_IN[W-1];
    a_mag     = a_neg ? -bus.OperandA_IN : bus.OperandA_IN;
    b_mag     = b_neg ? -bus.OperandB_IN : bus.OperandB_IN;
    run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Quotient and product share a sign; the remainder follows the dividend.
    prod      = neg_q ? -acc_q : acc_q;
    quot      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem       = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  muldiv_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_STEP   (MUL_STEP)
  ) u_step (
    .mode_div (run_div),
    .acc_in   (acc_q),
    .operand  (opb_q),
    .acc_out  (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start_IN && !bus.Flush_IN) begin
          case (op_in)
            OP_MTHI: begin
              hi_d   = bus.OperandA_IN;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.OperandA_IN;
              done_d = 1'b1;
            end
`ifndef HILO_MULDIV_ACCUM_EN
            OP_MADD, OP_MSUB: begin
              done_d = 1'b1;
            end
`endif
            default: begin
              op_d       = op_in;
              acc_d      = {{W{1'b0}}, a_mag};
              opb_d      = b_mag;
              neg_d      = a_neg ^ b_neg;
              rem_neg_d  = a_neg;
              cnt_d      = '0;
              div_zero_d = in_is_div && (bus.OperandB_IN == '0);
              state_d    = (in_is_div && (bus.OperandB_IN == '0)) ? ST_FIX : ST_RUN;
            end
          endcase
        end
      end

      ST_RUN: begin
        if (bus.Flush_IN) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + C_CNT_ONE;
          if (cnt_q == (run_div ? C_DIV_LAST : C_MUL_LAST)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.Flush_IN) begin
          done_d = 1'b1;
          if (div_zero_q) begin
            dz_d = 1'b1;
          end else begin
            case (op_q)
              OP_DIV, OP_DIVU: begin
                lo_d = quot;
                hi_d = rem;
              end
`ifdef HILO_MULDIV_ACCUM_EN
              OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
              OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
              default: {hi_d, lo_d} = prod;
            endcase
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULT;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign bus.Busy_OUT    = (state_q != ST_IDLE);
  assign bus.Done_OUT    = done_q;
  assign bus.DivZero_OUT = dz_q;
  assign bus.HI_OUT      = hi_q;
  assign bus.LO_OUT      = lo_q;
endmodule
`default_nettype wire
